// File: rtl/pid_pkg.sv
// Shared encodings for the PWM actuator and the PI controllers: FSM states and the
// clamp-result flag.
package pid_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } pwm_state_e;

  typedef enum logic [1:0] {
    SatNone = 2'b00,
    SatLo   = 2'b01,
    SatHi   = 2'b10
  } sat_e;

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of a signed 32-bit word into [0, Limit].
// Also used on the controller output.
module sat_clamp
  import pid_pkg::*;
#(
  parameter int unsigned Limit = 1000,
  parameter int unsigned OutW  = 16
) (
  input  logic signed [31:0]   val_i,
  output logic        [OutW-1:0] val_o,
  output sat_e                 sat_o
);

  // Compare at full signed width so large words never alias into range.
  localparam logic signed [31:0] LimitS = 32'(Limit);

  always_comb begin
    val_o = '0;
    sat_o = SatNone;
    if (val_i < 0) begin
      sat_o = SatLo;
    end else if (val_i > LimitS) begin
      val_o = OutW'(Limit);
      sat_o = SatHi;
    end else begin
      val_o = val_i[OutW-1:0];
    end
  end

endmodule

// File: rtl/pwm_actuator.sv
// PWM actuator: applies a clamped control word as a duty cycle, updating only at period
// boundaries, and strobes the controller at each period start.
module pwm_actuator
  import pid_pkg::*;
#(
  parameter int unsigned PERIOD = 1000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] ctrl_in,
  input  logic               ctrl_valid,
  output logic               pwm_out,
  output logic               sample_strobe,
  output logic [CNT_W-1:0]   duty,
  output logic               sat_hi,
  output logic               sat_lo,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD - 1);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  sat_e             pend_sat_q, pend_sat_d;
  sat_e             sat_q, sat_d;
  logic             pwm_q, pwm_d;
  logic             strobe_q, strobe_d;

  logic [CNT_W-1:0] clamp_val;
  sat_e             clamp_sat;
  logic             running, wrap, start, load;

  sat_clamp #(
    .Limit(PERIOD),
    .OutW (CNT_W)
  ) u_clamp (
    .val_i(ctrl_in),
    .val_o(clamp_val),
    .sat_o(clamp_sat)
  );

  always_comb begin
    running = (state_q != StIdle);
    wrap    = running && (cnt_q == LastCnt);
    start   = (state_q == StIdle) && en;
    load    = start || wrap;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StStop;
      StStop: begin
        if (en)        state_d = StRun;
        else if (wrap) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = (!running || wrap) ? '0 : cnt_q + CNT_W'(1);

    pend_d     = pend_q;
    pend_sat_d = pend_sat_q;
    if (ctrl_valid) begin
      pend_d     = clamp_val;
      pend_sat_d = clamp_sat;
    end

    // Loading from pend_d lets a same-cycle valid word bypass the pending register.
    duty_d = duty_q;
    sat_d  = sat_q;
    if (load) begin
      duty_d = pend_d;
      sat_d  = pend_sat_d;
    end

    pwm_d    = running && (state_d != StIdle) && (cnt_q < duty_q);
    strobe_d = start || (wrap && (state_d == StRun));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_sat_q <= SatNone;
      duty_q     <= '0;
      sat_q      <= SatNone;
      pwm_q      <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_sat_q <= pend_sat_d;
      duty_q     <= duty_d;
      sat_q      <= sat_d;
      pwm_q      <= pwm_d;
      strobe_q   <= strobe_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign sample_strobe = strobe_q;
  assign duty          = duty_q;
  assign sat_hi        = (sat_q == SatHi);
  assign sat_lo        = (sat_q == SatLo);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_actuator.sv
// Directed bench for pwm_actuator with PERIOD=10; expected values are worked out by hand
// from the cycle position relative to the start edge.
module tb_pwm_actuator;

  localparam int unsigned Period = 10;
  localparam int unsigned CntW   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [31:0] ctrl_in;
  logic               ctrl_valid;
  logic               pwm_out;
  logic               sample_strobe;
  logic [CntW-1:0]    duty;
  logic               sat_hi;
  logic               sat_lo;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pat;
  int          strobes;

  pwm_actuator #(
    .PERIOD(Period),
    .CNT_W (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ctrl_in      (ctrl_in),
    .ctrl_valid   (ctrl_valid),
    .pwm_out      (pwm_out),
    .sample_strobe(sample_strobe),
    .duty         (duty),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are read 1 time unit after the edge, well clear of the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit k of pattern = pwm_out after the (k+1)-th tick.
  task automatic run_cycles(input int n, output logic [31:0] pattern, output int n_strobe);
    pattern  = '0;
    n_strobe = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      pattern[k] = pwm_out;
      if (sample_strobe) n_strobe++;
    end
  endtask

  task automatic pulse_valid(input int value);
    ctrl_in    = value;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    ctrl_in    = '0;
    ctrl_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_pwm", 32'(pwm_out), 0);
    check_eq("rst_duty", 32'(duty), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_strobe", 32'(sample_strobe), 0);
    check_eq("rst_sat", {30'd0, sat_hi, sat_lo}, 0);
    rst = 1'b0;

    // Basic run: pending 3 captured in IDLE, applied on start.
    pulse_valid(3);
    tick();
    check_eq("idle_duty_held", 32'(duty), 0);
    en = 1'b1;
    tick();
    check_eq("start_strobe", 32'(sample_strobe), 1);
    check_eq("start_duty", 32'(duty), 3);
    check_eq("start_busy", 32'(busy), 1);
    check_eq("start_pwm", 32'(pwm_out), 0);
    run_cycles(10, pat, strobes);
    check_eq("d3_pat0", pat, 32'h7);
    check_eq("d3_strb0", 32'(strobes), 1);
    run_cycles(10, pat, strobes);
    check_eq("d3_pat1", pat, 32'h7);
    check_eq("d3_strb1", 32'(strobes), 1);

    // Negative word clamps low.
    pulse_valid(-5);
    run_cycles(9, pat, strobes);
    check_eq("lo_duty", 32'(duty), 0);
    check_eq("lo_flags", {30'd0, sat_hi, sat_lo}, 32'h1);
    run_cycles(10, pat, strobes);
    check_eq("lo_pat", pat, 32'h0);
    check_eq("lo_strb", 32'(strobes), 1);

    // Oversized word clamps to PERIOD: constant high across the wrap.
    pulse_valid(50);
    run_cycles(9, pat, strobes);
    check_eq("hi_duty", 32'(duty), 10);
    check_eq("hi_flags", {30'd0, sat_hi, sat_lo}, 32'h2);
    run_cycles(10, pat, strobes);
    check_eq("hi_pat", pat, 32'h3FF);

    // Mid-period updates: last valid before the wrap wins, current pulse untouched.
    run_cycles(4, pat, strobes);
    pulse_valid(7);
    run_cycles(3, pat, strobes);
    check_eq("mid_pat", pat, 32'h7);
    pulse_valid(2);
    check_eq("mid_duty_held", 32'(duty), 10);
    check_eq("mid_pwm_held", 32'(pwm_out), 1);
    tick();
    check_eq("mid_new_duty", 32'(duty), 2);
    check_eq("mid_new_flags", {30'd0, sat_hi, sat_lo}, 32'h0);
    run_cycles(10, pat, strobes);
    check_eq("d2_pat", pat, 32'h3);
    check_eq("d2_strb", 32'(strobes), 1);

    // Valid on the wrap cycle bypasses pending.
    run_cycles(9, pat, strobes);
    pulse_valid(6);
    check_eq("wrap_duty", 32'(duty), 6);
    check_eq("wrap_strobe", 32'(sample_strobe), 1);
    run_cycles(10, pat, strobes);
    check_eq("d6_pat", pat, 32'h3F);
    check_eq("d6_strb", 32'(strobes), 1);

    // Stop request at cnt=3: period completes, then IDLE.
    run_cycles(3, pat, strobes);
    en = 1'b0;
    tick();
    check_eq("stop_busy", 32'(busy), 1);
    check_eq("stop_pwm", 32'(pwm_out), 1);
    run_cycles(6, pat, strobes);
    check_eq("stop_pat", pat, 32'h3);
    check_eq("stop_strb", 32'(strobes), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_pwm", 32'(pwm_out), 0);
    run_cycles(10, pat, strobes);
    check_eq("idle_pat", pat, 32'h0);
    check_eq("idle_strb", 32'(strobes), 0);
    check_eq("idle_busy2", 32'(busy), 0);

    // Reset mid-period with duty=8.
    pulse_valid(8);
    en = 1'b1;
    tick();
    check_eq("d8_duty", 32'(duty), 8);
    check_eq("d8_strobe", 32'(sample_strobe), 1);
    run_cycles(5, pat, strobes);
    check_eq("d8_pat", pat, 32'h1F);
    rst = 1'b1;
    tick();
    check_eq("mrst_pwm", 32'(pwm_out), 0);
    check_eq("mrst_duty", 32'(duty), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_strobe", 32'(sample_strobe), 0);
    check_eq("mrst_sat", {30'd0, sat_hi, sat_lo}, 0);

    // Restart with a same-cycle valid on the start edge.
    rst = 1'b0;
    pulse_valid(4);
    check_eq("re_duty", 32'(duty), 4);
    check_eq("re_strobe", 32'(sample_strobe), 1);
    check_eq("re_busy", 32'(busy), 1);
    run_cycles(9, pat, strobes);
    check_eq("re_pat", pat, 32'hF);
    check_eq("re_strb_none", 32'(strobes), 0);
    tick();
    check_eq("re_strb_wrap", 32'(sample_strobe), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_actuator.md
PWM_ACTUATOR -- requirements
Module: pwm_actuator

Interface
REQ-001 Parameter PERIOD, default 1000: PWM period in clk cycles; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the period counter and duty; must satisfy 2^CNT_W > PERIOD.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 en  input  1  run request; high starts or keeps PWM, low requests a stop at the period boundary.
REQ-006 ctrl_in  input  32 signed  control word from the PI controller.
REQ-007 ctrl_valid  input  1  ctrl_in qualifier; one-cycle pulse or level, sampled every cycle.
REQ-008 pwm_out  output  1  registered PWM drive.
REQ-009 sample_strobe  output  1  one-cycle pulse at each period start; controller samples error on it.
REQ-010 duty  output  CNT_W  duty currently applied, in counts.
REQ-011 sat_hi  output  1  high while the applied duty came from a clamped-high ctrl word.
REQ-012 sat_lo  output  1  high while the applied duty came from a clamped-low ctrl word.
REQ-013 busy  output  1  high in RUN and STOP states.

Function
REQ-014 State machine with states IDLE, RUN and STOP.
REQ-015 IDLE -> RUN when en=1; RUN -> STOP when en=0; STOP -> RUN when en=1; STOP -> IDLE at the period wrap.
REQ-016 Period counter cnt: held at 0 in IDLE; in RUN/STOP counts 0..PERIOD-1, then wraps to 0.
REQ-017 Wrap condition: cnt==PERIOD-1 in RUN or STOP.
REQ-018 On ctrl_valid=1 the pending register captures clamp(ctrl_in); the last valid before a wrap wins.
REQ-019 Clamp rule: ctrl_in<0 -> 0 with lo flag; ctrl_in>PERIOD -> PERIOD with hi flag; otherwise ctrl_in[CNT_W-1:0] with both flags clear.
REQ-020 The compare is full 32-bit signed; no truncation before the clamp.
REQ-021 duty, sat_hi and sat_lo load from pending only on the cycle leaving IDLE for RUN, and at each wrap.
REQ-022 If ctrl_valid and the wrap (or IDLE->RUN) coincide, the same-cycle ctrl_in is applied directly, bypassing pending.
REQ-023 pwm_out in cycle t+1 equals (cnt_t < duty_t) while in RUN/STOP; 0 in IDLE.
REQ-024 duty=0 gives constant low; duty=PERIOD gives constant high, with no glitch at the wrap.
REQ-025 sample_strobe is 1 in the cycle after IDLE->RUN and in the cycle after each wrap that stays in RUN; it is 0 otherwise.
REQ-026 Duty changes only at period boundaries; a mid-period ctrl_valid never alters the current pulse.

Reset
REQ-027 rst=1 forces state IDLE, cnt=0, pending=0, duty=0, pwm_out=0, sample_strobe=0, sat_hi=0, sat_lo=0 and busy=0 at the next edge.
REQ-028 Reset overrides en and ctrl_valid, including mid-period; there is no partial-period completion.

Structure
REQ-029 State encoding and the clamp-result flag encoding are defined in the shared package pid_pkg, which the PI controllers also use.
REQ-030 Clamp logic is a combinational sub-module, sat_clamp, parameterised by the upper limit and reusable for the controller output.
REQ-031 Single module otherwise, with no additional clocks and no latches.

Verification (PERIOD=10)
REQ-032 ctrl_in=3 with valid, then en=1 -> strobe in cycle 1; pwm_out high for 3 of every 10 cycles; duty=3.
REQ-033 ctrl_in=-5, later 50 -> duty=0 with sat_lo=1 and pwm_out constantly low; then duty=10 with sat_hi=1 and pwm_out constantly high.
REQ-034 Mid-period valid 7, then 2 at cnt=4 and 8 -> current pulse unchanged; next period duty=2.
REQ-035 Valid 6 coinciding with the wrap -> duty=6 in the immediately following period.
REQ-036 en dropped at cnt=3 -> period completes, state IDLE after the wrap, pwm_out=0, busy=0, no further strobes.
REQ-037 rst at cnt=5 with duty=8 -> next cycle all outputs 0 and IDLE; a new en restarts at cnt=0.
